// File: rtl/hazard_interlock_pkg.sv
// Shared definitions for the decode-stage hazard interlock.
// Holds mode encodings, default bubble opcode/function and scoreboard field widths.
// Also provides the saturating increment used by the stall counter.
package hazard_interlock_pkg;

    // Interlock policy selected by the MODE parameter
    localparam int HZ_MODE_FIXED     = 0;  // fixed stall after every issued instr
    localparam int HZ_MODE_INTERLOCK = 1;  // full RAW interlock, no forwarding
    localparam int HZ_MODE_LOADUSE   = 2;  // load-use interlock only, forwarding present

    // Instruction driven toward execute while a bubble is inserted
    localparam logic [5:0] HZ_NOP_OPCODE = 6'h00;
    localparam logic [5:0] HZ_NOP_FUNC   = 6'h15;

    // Scoreboard entry field widths (address width is the REG_AW parameter)
    localparam int SB_VALID_W = 1;
    localparam int SB_LOAD_W  = 1;

    // Width of the fixed-stall down-counter (STALL_CYCLES range 0..15)
    localparam int HZ_CNT_W = 4;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/MUX2_n.sv
// Generic N-bit two-input multiplexer.
// Latency: combinational.
// Backpressure: none; ports a, b (data), sel (1 selects b), y (result).
module MUX2_n #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sel,
    output logic [N-1:0] y
);

    assign y = sel ? b : a;

endmodule

// File: rtl/hazard_interlock_dest_scoreboard.sv
// Shift-register scoreboard of in-flight destination registers with per-stage source match.
// Latency: entries advance one stage per clock; match outputs are combinational on sources.
// Backpressure: none; ports clk/reset, push (valid/addr/load into Exe slot), rs1/rs2 probes, match/load_match per stage.
module hazard_interlock_dest_scoreboard
    import hazard_interlock_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [AW-1:0]    push_addr,
    input  logic             push_load,
    input  logic [AW-1:0]    rs1,
    input  logic [AW-1:0]    rs2,
    input  logic             rs1_used,
    input  logic             rs2_used,
    output logic [DEPTH-1:0] match,
    output logic [DEPTH-1:0] load_match
);

    // Index 0 is the instr now in Exe, index DEPTH-1 is the one in WB
    logic [SB_VALID_W*DEPTH-1:0] ent_valid;
    logic [SB_LOAD_W*DEPTH-1:0]  ent_load;
    logic [AW-1:0]               ent_addr [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ent_valid <= '0;
            ent_load  <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                ent_addr[k] <= '0;
            end
        end else begin
            ent_valid   <= {ent_valid[DEPTH-2:0], push};
            ent_load    <= {ent_load[DEPTH-2:0], push_load};
            ent_addr[0] <= push_addr;
            for (int k = 1; k < DEPTH; k++) begin
                ent_addr[k] <= ent_addr[k-1];
            end
        end
    end

    // r0 writers are never pushed as valid, so a read of r0 can never match
    always_comb begin
        match      = '0;
        load_match = '0;
        for (int k = 0; k < DEPTH; k++) begin
            match[k] = ent_valid[k] &&
                       ((rs1_used && (rs1 == ent_addr[k])) ||
                        (rs2_used && (rs2 == ent_addr[k])));
            load_match[k] = match[k] && ent_load[k];
        end
    end

endmodule

// File: rtl/hazard_interlock.sv
// Decode-stage RAW hazard interlock: stalls PC/IF-ID and injects NOP bubbles toward execute.
// Latency: zero-cycle detection; stall/bubble are combinational on the decode instr and scoreboard.
// Backpressure: PC_stall holds fetch/decode; Flush overrides stall and forces a bubble.
module hazard_interlock
    import hazard_interlock_pkg::*;
#(
    parameter int         MODE         = HZ_MODE_INTERLOCK,
    parameter int         PIPE_DEPTH   = 4,
    parameter int         STALL_CYCLES = 4,
    parameter int         REG_AW       = 5,
    parameter logic [5:0] NOP_OPCODE   = HZ_NOP_OPCODE,
    parameter logic [5:0] NOP_FUNC     = HZ_NOP_FUNC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] Rs1,
    input  logic [REG_AW-1:0] Rs2,
    input  logic              Rs1_Used,
    input  logic              Rs2_Used,
    input  logic [REG_AW-1:0] Rd,
    input  logic              RegWr,
    input  logic              IsLoad,
    input  logic              Flush,
    input  logic [5:0]        OpCode_In,
    input  logic [5:0]        Function_In,
    output logic [5:0]        OpCode,
    output logic [5:0]        Function,
    output logic              PC_stall,
    output logic [31:0]       Stall_Count
);

    localparam logic [HZ_CNT_W-1:0] STALL_LOAD = HZ_CNT_W'(STALL_CYCLES);

    logic                  issue;
    logic                  hazard;
    logic                  bubble;
    logic                  push;
    logic [PIPE_DEPTH-1:0] match;
    logic [PIPE_DEPTH-1:0] load_match;
    logic [HZ_CNT_W-1:0]   cnt;

    // Only the Exe-stage load flag and the pre-WB matches drive any policy
    logic unused_sb_bits;
    assign unused_sb_bits = ^{match[PIPE_DEPTH-1], load_match[PIPE_DEPTH-1:1]};

    assign issue = !PC_stall && !Flush;
    assign push  = issue && RegWr && (Rd != '0);

    hazard_interlock_dest_scoreboard #(
        .DEPTH (PIPE_DEPTH),
        .AW    (REG_AW)
    ) u_scoreboard (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_addr  (Rd),
        .push_load  (IsLoad),
        .rs1        (Rs1),
        .rs2        (Rs2),
        .rs1_used   (Rs1_Used),
        .rs2_used   (Rs2_Used),
        .match      (match),
        .load_match (load_match)
    );

    // WB entry is excluded from the full interlock: the regfile writes through
    // to a same-cycle read, so a producer in WB no longer blocks its consumer.
    always_comb begin
        hazard = 1'b0;
        case (MODE)
            HZ_MODE_INTERLOCK: hazard = |match[PIPE_DEPTH-2:0];
            HZ_MODE_LOADUSE:   hazard = load_match[0];
            default:           hazard = (cnt != '0);
        endcase
    end

    assign PC_stall = hazard && !Flush;
    assign bubble   = PC_stall || Flush;

    // Fixed-stall counter; kept in every mode, only consulted in the fixed mode.
    // A flush cancels any remaining fixed stall.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (Flush) begin
            cnt <= '0;
        end else if (issue) begin
            cnt <= STALL_LOAD;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Stall_Count <= '0;
        end else if (PC_stall) begin
            Stall_Count <= sat_inc32(Stall_Count);
        end
    end

    MUX2_n #(
        .N (12)
    ) u_bubble_mux (
        .a   ({OpCode_In, Function_In}),
        .b   ({NOP_OPCODE, NOP_FUNC}),
        .sel (bubble),
        .y   ({OpCode, Function})
    );

endmodule

// File: tb/tb_hazard_interlock.sv
module tb_hazard_interlock;

    localparam logic [5:0] OPC_IN = 6'h23;
    localparam logic [5:0] FN_IN  = 6'h2A;
    localparam logic [5:0] OPC_NOP = 6'h00;
    localparam logic [5:0] FN_NOP  = 6'h15;

    logic       clk;
    logic       reset;
    logic [4:0] Rs1, Rs2, Rd;
    logic       Rs1_Used, Rs2_Used, RegWr, IsLoad, Flush;
    logic [5:0] OpCode_In, Function_In;

    logic [5:0]  opc0, fn0, opc1, fn1, opc2, fn2;
    logic        stall0, stall1, stall2;
    logic [31:0] cnt0, cnt1, cnt2;

    int n_checks = 0;
    int n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    hazard_interlock #(.MODE(0), .PIPE_DEPTH(4), .STALL_CYCLES(4)) dut0 (
        .clk(clk), .reset(reset), .Rs1(Rs1), .Rs2(Rs2), .Rs1_Used(Rs1_Used), .Rs2_Used(Rs2_Used),
        .Rd(Rd), .RegWr(RegWr), .IsLoad(IsLoad), .Flush(Flush), .OpCode_In(OpCode_In),
        .Function_In(Function_In), .OpCode(opc0), .Function(fn0), .PC_stall(stall0), .Stall_Count(cnt0));

    hazard_interlock #(.MODE(1), .PIPE_DEPTH(4), .STALL_CYCLES(4)) dut1 (
        .clk(clk), .reset(reset), .Rs1(Rs1), .Rs2(Rs2), .Rs1_Used(Rs1_Used), .Rs2_Used(Rs2_Used),
        .Rd(Rd), .RegWr(RegWr), .IsLoad(IsLoad), .Flush(Flush), .OpCode_In(OpCode_In),
        .Function_In(Function_In), .OpCode(opc1), .Function(fn1), .PC_stall(stall1), .Stall_Count(cnt1));

    hazard_interlock #(.MODE(2), .PIPE_DEPTH(4), .STALL_CYCLES(4)) dut2 (
        .clk(clk), .reset(reset), .Rs1(Rs1), .Rs2(Rs2), .Rs1_Used(Rs1_Used), .Rs2_Used(Rs2_Used),
        .Rd(Rd), .RegWr(RegWr), .IsLoad(IsLoad), .Flush(Flush), .OpCode_In(OpCode_In),
        .Function_In(Function_In), .OpCode(opc2), .Function(fn2), .PC_stall(stall2), .Stall_Count(cnt2));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [4:0] r1, input logic u1, input logic [4:0] r2, input logic u2,
                         input logic [4:0] rd, input logic wr, input logic ld, input logic fl);
        Rs1 = r1; Rs1_Used = u1; Rs2 = r2; Rs2_Used = u2;
        Rd = rd; RegWr = wr; IsLoad = ld; Flush = fl;
        OpCode_In = OPC_IN; Function_In = FN_IN;
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow 2 units later
    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    // Idle vector is a flushed slot so nothing issues and the fixed counter stays clear
    task automatic apply_reset();
        next_cyc();
        reset = 1'b0;
        drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        next_cyc();
        reset = 1'b1;
    endtask

    logic [9:0] pat_fixed;
    logic [3:0] pat_raw;

    initial begin
        reset = 1'b0;
        drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        #3;
        // Reset state: no stall, pass-through, zero counters
        check("rst_stall0", 32'(stall0), 32'd0);
        check("rst_stall1", 32'(stall1), 32'd0);
        check("rst_stall2", 32'(stall2), 32'd0);
        check("rst_cnt1", cnt1, 32'd0);
        check("rst_opc1", 32'(opc1), 32'(OPC_IN));
        check("rst_fn1", 32'(fn1), 32'(FN_IN));

        // MODE 0 streaming: stall pattern 0,1,1,1,1,0,1,1,1,1
        apply_reset();
        pat_fixed = 10'b1111011110;
        for (int i = 0; i < 10; i++) begin
            next_cyc();
            drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0);
            #2;
            check($sformatf("m0_stall_c%0d", i), 32'(stall0), 32'(pat_fixed[i]));
            check($sformatf("m0_opc_c%0d", i), 32'(opc0), pat_fixed[i] ? 32'(OPC_NOP) : 32'(OPC_IN));
            check($sformatf("m0_fn_c%0d", i), 32'(fn0), pat_fixed[i] ? 32'(FN_NOP) : 32'(FN_IN));
        end
        next_cyc();
        #2;
        check("m0_stall_count", cnt0, 32'd8);

        // MODE 1: add r3 then dependent reader of r3 -> 3 bubbles then issue
        apply_reset();
        next_cyc();
        drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
        #2;
        check("m1_raw_c0", 32'(stall1), 32'd0);
        pat_raw = 4'b0111;
        for (int i = 0; i < 4; i++) begin
            next_cyc();
            drive(5'd3, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
            #2;
            check($sformatf("m1_raw_stall_c%0d", i + 1), 32'(stall1), 32'(pat_raw[i]));
            check($sformatf("m1_raw_opc_c%0d", i + 1), 32'(opc1), pat_raw[i] ? 32'(OPC_NOP) : 32'(OPC_IN));
            check($sformatf("m1_raw_fn_c%0d", i + 1), 32'(fn1), pat_raw[i] ? 32'(FN_NOP) : 32'(FN_IN));
            // ALU producer: load-use mode never stalls
            check($sformatf("m2_alu_stall_c%0d", i + 1), 32'(stall2), 32'd0);
        end
        check("m1_raw_count", cnt1, 32'd3);

        // MODE 1: sources hit different stages; stall until younger producer reaches WB
        apply_reset();
        next_cyc();
        drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0);
        next_cyc();
        drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
        #2;
        check("m1_dual_c1", 32'(stall1), 32'd0);
        for (int i = 0; i < 4; i++) begin
            next_cyc();
            drive(5'd2, 1'b1, 5'd6, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
            #2;
            check($sformatf("m1_dual_c%0d", i + 2), 32'(stall1), 32'(pat_raw[i]));
        end

        // MODE 2: load r5 then use r5 -> exactly one stall
        apply_reset();
        next_cyc();
        drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
        #2;
        check("m2_ld_c0", 32'(stall2), 32'd0);
        next_cyc();
        drive(5'd0, 1'b0, 5'd5, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
        #2;
        check("m2_ld_c1", 32'(stall2), 32'd1);
        check("m2_ld_opc_c1", 32'(opc2), 32'(OPC_NOP));
        check("m2_ld_fn_c1", 32'(fn2), 32'(FN_NOP));
        next_cyc();
        #2;
        check("m2_ld_c2", 32'(stall2), 32'd0);
        next_cyc();
        drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        #2;
        check("m2_ld_count", cnt2, 32'd1);

        // MODE 1: r0 writer then r0 reader -> no stall
        apply_reset();
        next_cyc();
        drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        next_cyc();
        drive(5'd0, 1'b1, 5'd0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
        #2;
        check("m1_r0", 32'(stall1), 32'd0);

        // Flush over pending hazard: no stall, bubble out, next unrelated instr issues
        apply_reset();
        next_cyc();
        drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
        next_cyc();
        drive(5'd7, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b1);
        #2;
        check("fl_stall1", 32'(stall1), 32'd0);
        check("fl_opc1", 32'(opc1), 32'(OPC_NOP));
        check("fl_fn1", 32'(fn1), 32'(FN_NOP));
        check("fl_stall0", 32'(stall0), 32'd0);
        next_cyc();
        drive(5'd9, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0);
        #2;
        check("fl_next_stall1", 32'(stall1), 32'd0);
        check("fl_next_opc1", 32'(opc1), 32'(OPC_IN));
        check("fl_next_stall0", 32'(stall0), 32'd0);

        // MODE 1: reset asserted mid-stall ends the stall at once
        apply_reset();
        next_cyc();
        drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
        next_cyc();
        drive(5'd3, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
        #2;
        check("mr_stall_c1", 32'(stall1), 32'd1);
        next_cyc();
        #2;
        check("mr_stall_c2", 32'(stall1), 32'd1);
        check("mr_count_c2", cnt1, 32'd1);
        #1;
        reset = 1'b0;
        #1;
        check("mr_stall_rst", 32'(stall1), 32'd0);
        check("mr_count_rst", cnt1, 32'd0);
        check("mr_opc_rst", 32'(opc1), 32'(OPC_IN));
        next_cyc();
        reset = 1'b1;
        #2;
        check("mr_stall_rel", 32'(stall1), 32'd0);
        next_cyc();
        #2;
        check("mr_stall_rel2", 32'(stall1), 32'd0);
        check("mr_count_rel2", cnt1, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
